// File: rtl/q_twos_to_signmag.sv
// Converts double-width two's-complement Q(2N,2Q) values to N-bit sign-magnitude Q(N,Q).
// Two-stage valid/ready pipeline with round-half-away-from-zero, saturation and a saturation event counter.
module q_twos_to_signmag #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count,
  output logic             sat_sticky
);

  localparam int W2 = 2 * N;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_minneg;
  logic [W2-1:0]    r_s1_mag;
  logic             r_s2_valid;
  logic [N-1:0]     r_out_data;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_sat_count;
  logic             r_sat_sticky;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_in_sign;
  logic [W2-1:0]    w_in_mag;
  logic             w_in_minneg;
  logic             w_round;
  logic [W2:0]      w_r;
  logic             w_ovf;
  logic             w_sat;
  logic [N-2:0]     w_mag_o;
  logic [N-1:0]     w_out;
  logic             w_sat_evt;

  // A stage may load when it is empty or the stage after it is moving.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_in_sign   = in_data[W2-1];
  assign w_in_mag    = w_in_sign ? ((~in_data) + W2'(1)) : in_data;
  assign w_in_minneg = (in_data == {1'b1, {(W2-1){1'b0}}});

  generate
    if (Q == 0) begin : g_no_round
      assign w_round = 1'b0;
    end else begin : g_round
      assign w_round = r_s1_mag[Q-1];
    end
  endgenerate

  // Rounding on the magnitude gives round-half-away-from-zero for the signed value.
  assign w_r     = ({1'b0, r_s1_mag} >> Q) + {{W2{1'b0}}, w_round};
  assign w_ovf   = |w_r[W2:N-1];
  assign w_sat   = r_s1_minneg || w_ovf;
  assign w_mag_o = w_sat ? {(N-1){1'b1}} : w_r[N-2:0];
  assign w_out   = {r_s1_sign && (|w_mag_o), w_mag_o};

  assign w_sat_evt = r_s2_valid && out_ready && r_out_sat;

  // NOTE: stage-1 payload is qualified by r_s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1_sign   <= w_in_sign;
      r_s1_mag    <= w_in_mag;
      r_s1_minneg <= w_in_minneg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_out_data   <= '0;
      r_out_sat    <= 1'b0;
      r_sat_count  <= '0;
      r_sat_sticky <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_out;
          r_out_sat  <= w_sat;
        end
      end
      // Clear wins over a coincident saturated transfer.
      if (sat_clr) begin
        r_sat_count  <= '0;
        r_sat_sticky <= 1'b0;
      end else if (w_sat_evt) begin
        r_sat_sticky <= 1'b1;
        if (r_sat_count != {CNT_W{1'b1}}) begin
          r_sat_count <= r_sat_count + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;
  assign sat_count  = r_sat_count;
  assign sat_sticky = r_sat_sticky;

endmodule
